// File: rtl/vga_pkg.sv
// Shared definitions for the VGA fetch controller: display geometry defaults,
// burst sizing and the fetch FSM state encoding.
package vga_pkg;

   localparam int H_ACTIVE_DEF   = 640;
   localparam int V_ACTIVE_DEF   = 480;
   localparam int BURST_LEN_DEF  = 16;
   localparam int FIFO_DEPTH_DEF = 64;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_CHECK      = 3'd1,
      ST_REQ        = 3'd2,
      ST_RECV       = 3'd3,
      ST_WAIT_FRAME = 3'd4
   } fetch_state_t;

   function automatic int unsigned frame_words(input int unsigned h, input int unsigned v);
      return h * v;
   endfunction

endpackage

// File: rtl/vga_fetch_ctrl_if.sv
// Frame-buffer memory port used by the fetch controller (request/grant burst bus).
interface vga_fetch_ctrl_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 24
);
   // Handshake: mem_req rises with mem_addr and both hold, unchanged, until the
   // cycle mem_gnt is seen high (one-cycle accept). Each grant is followed by
   // exactly BURST_LEN in-order mem_rvalid beats, possibly with idle gaps.
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_addr,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/vga_fetch_ctrl.sv
// Keeps the VGA pixel FIFO filled by issuing fixed-length frame-buffer bursts,
// resynchronising to each frame start and flagging display-side underruns.
module vga_fetch_ctrl
   import vga_pkg::*;
#(
   parameter int DATA_W     = 24,
   parameter int ADDR_W     = 19,
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int BURST_LEN  = BURST_LEN_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int LVL_W      = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [ADDR_W-1:0]  frame_base,
   input  logic               frame_start,
   input  logic [LVL_W-1:0]   fifo_level,
   input  logic               fifo_rd,
   input  logic               fifo_empty,
   output logic               fifo_wr,
   output logic [DATA_W-1:0]  fifo_wdata,
   output logic               fifo_flush,
   vga_fetch_ctrl_if.master   mem,
   output logic               busy,
   output logic               frame_done,
   output logic               underrun,
   output fetch_state_t       fsm_state
);

   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(frame_words(H_ACTIVE, V_ACTIVE));
   localparam logic [ADDR_W-1:0] BURST_WORDS = ADDR_W'(BURST_LEN);
   localparam logic [LVL_W-1:0]  ROOM_LEVEL  = LVL_W'(FIFO_DEPTH - BURST_LEN);
   localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] word_cnt;
   logic [BEAT_W-1:0] beat_cnt;
   logic              pending;
   logic              restart;
   logic              beat;
   logic              last_beat;
   logic              room;
   logic              frame_end;

   assign beat      = (state_q == ST_RECV) && mem.mem_rvalid;
   assign last_beat = beat && (beat_cnt == LAST_BEAT);
   assign room      = (fifo_level <= ROOM_LEVEL);
   assign frame_end = (word_cnt == FRAME_WORDS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // restart is decided here so the datapath sees exactly the transitions that reload the frame
   always_comb begin
      state_d = state_q;
      restart = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable && frame_start) begin
               restart = 1'b1;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (!enable)          state_d = ST_IDLE;
            else if (frame_start) restart = 1'b1;
            else if (frame_end)   state_d = ST_WAIT_FRAME;
            else if (room)        state_d = ST_REQ;
         end
         ST_REQ: begin
            if (mem.mem_gnt) state_d = ST_RECV;
         end
         ST_RECV: begin
            if (last_beat) begin
               state_d = ST_CHECK;
               restart = pending | frame_start;
            end
         end
         ST_WAIT_FRAME: begin
            if (!enable) state_d = ST_IDLE;
            else if (frame_start) begin
               restart = 1'b1;
               state_d = ST_CHECK;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem.mem_req  = (state_q == ST_REQ);
      mem.mem_addr = base_q + word_cnt;
      busy         = (state_q != ST_IDLE);
      fsm_state    = state_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q     <= '0;
         word_cnt   <= '0;
         beat_cnt   <= '0;
         pending    <= 1'b0;
         underrun   <= 1'b0;
         fifo_wr    <= 1'b0;
         fifo_wdata <= '0;
         fifo_flush <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         fifo_wr    <= beat;
         fifo_flush <= restart;
         frame_done <= last_beat && !restart && ((word_cnt + BURST_WORDS) == FRAME_WORDS);
         if (beat) fifo_wdata <= mem.mem_rdata;

         if ((state_q == ST_REQ) && mem.mem_gnt) beat_cnt <= '0;
         else if (beat)                          beat_cnt <= beat_cnt + BEAT_W'(1);

         // a frame start during a burst is deferred until the burst's last beat
         if (restart) begin
            base_q   <= frame_base;
            word_cnt <= '0;
            pending  <= 1'b0;
            underrun <= 1'b0;
         end else begin
            if (last_beat) word_cnt <= word_cnt + BURST_WORDS;
            if (frame_start && ((state_q == ST_REQ) || (state_q == ST_RECV))) pending <= 1'b1;
            if (fifo_rd && fifo_empty) underrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vga_fetch_ctrl.sv
// Self-checking bench for vga_fetch_ctrl on a small 8x4 frame with 4-word bursts.
module tb_vga_fetch_ctrl;
   import vga_pkg::*;

   localparam int DATA_W     = 24;
   localparam int ADDR_W     = 19;
   localparam int H_ACTIVE   = 8;
   localparam int V_ACTIVE   = 4;
   localparam int BURST_LEN  = 4;
   localparam int FIFO_DEPTH = 16;
   localparam int LVL_W      = 5;

   logic              clk;
   logic              rst;
   logic              enable;
   logic [ADDR_W-1:0] frame_base;
   logic              frame_start;
   logic [LVL_W-1:0]  fifo_level;
   logic              fifo_rd;
   logic              fifo_empty;
   logic              fifo_wr;
   logic [DATA_W-1:0] fifo_wdata;
   logic              fifo_flush;
   logic              busy;
   logic              frame_done;
   logic              underrun;
   fetch_state_t      fsm_state;

   vga_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m ();

   vga_fetch_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
      .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .frame_base(frame_base),
      .frame_start(frame_start), .fifo_level(fifo_level), .fifo_rd(fifo_rd),
      .fifo_empty(fifo_empty), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
      .fifo_flush(fifo_flush), .mem(m), .busy(busy), .frame_done(frame_done),
      .underrun(underrun), .fsm_state(fsm_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // scoreboard state
   logic [DATA_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int n_wr     = 0;
   int n_flush  = 0;
   int n_done   = 0;
   logic beats_valid = 1'b1;
   logic prev_beat   = 1'b0;
   logic [DATA_W-1:0] exp_word;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // output monitor: write latency, write data, event counters
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_beat = 1'b0;
         end else begin
            if (fifo_wr || prev_beat) check("wr_latency", 32'(fifo_wr), 32'(prev_beat));
            if (fifo_wr) begin
               n_wr++;
               if (exp_q.size() == 0) check("wr_unexpected", 32'(fifo_wr), 32'd0);
               else begin
                  exp_word = exp_q.pop_front();
                  check("wr_data", 32'(fifo_wdata), 32'(exp_word));
               end
            end
            if (fifo_flush) n_flush++;
            if (frame_done) n_done++;
            prev_beat = m.mem_rvalid && beats_valid;
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_fs();
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic wait_req(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (m.mem_req) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("req_timeout", 32'(m.mem_req), 32'd1);
   endtask

   task automatic do_burst(input logic [ADDR_W-1:0] exp_addr, input int gnt_dly, input int fs_beat);
      bit seen;
      logic [DATA_W-1:0] d;
      wait_req(seen);
      if (!seen) return;
      check("req_addr", 32'(m.mem_addr), 32'(exp_addr));
      for (int i = 0; i < gnt_dly; i++) begin
         tick();
         @(negedge clk);
         check("req_hold", 32'(m.mem_req), 32'd1);
         check("addr_hold", 32'(m.mem_addr), 32'(exp_addr));
      end
      tick();
      m.mem_gnt = 1'b1;
      tick();
      m.mem_gnt = 1'b0;
      for (int b = 0; b < BURST_LEN; b++) begin
         if ($urandom_range(0, 1) == 1) begin
            m.mem_rvalid = 1'b0;
            tick();
         end
         d = DATA_W'($urandom);
         m.mem_rvalid = 1'b1;
         m.mem_rdata  = d;
         exp_q.push_back(d);
         frame_start = (b == fs_beat);
         tick();
         frame_start = 1'b0;
      end
      m.mem_rvalid = 1'b0;
   endtask

   initial begin
      bit seen;
      logic [DATA_W-1:0] d;
      int flush_base;
      rst = 1'b1; enable = 1'b0; frame_base = 19'h100; frame_start = 1'b0;
      fifo_level = '0; fifo_rd = 1'b0; fifo_empty = 1'b0;
      m.mem_gnt = 1'b0; m.mem_rvalid = 1'b0; m.mem_rdata = '0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_req", 32'(m.mem_req), 32'd0);
      check("rst_addr", 32'(m.mem_addr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr", 32'(fifo_wr), 32'd0);
      check("rst_flush", 32'(fifo_flush), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
      tick();
      rst = 1'b0;

      // frame 1: eight bursts back to back
      enable = 1'b1;
      pulse_fs();
      for (int k = 0; k < 8; k++) do_burst(ADDR_W'(19'h100 + 4 * k), 0, -1);
      repeat (4) @(negedge clk);
      check("f1_wr_count", 32'(n_wr), 32'd32);
      check("f1_frame_done", 32'(n_done), 32'd1);
      check("f1_flush", 32'(n_flush), 32'd1);
      check("f1_state", 32'(fsm_state), 32'(ST_WAIT_FRAME));
      check("f1_no_req", 32'(m.mem_req), 32'd0);
      check("f1_q_empty", 32'(exp_q.size()), 32'd0);

      // FIFO room threshold
      fifo_level = 5'd13;
      pulse_fs();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("lvl13_no_req", 32'(m.mem_req), 32'd0);
      end
      check("lvl13_state", 32'(fsm_state), 32'(ST_CHECK));
      tick();
      fifo_level = 5'd12;
      @(negedge clk);
      check("lvl12_not_yet", 32'(m.mem_req), 32'd0);
      @(negedge clk);
      check("lvl12_req", 32'(m.mem_req), 32'd1);

      // delayed grant
      do_burst(19'h100, 10, -1);
      fifo_level = 5'd0;

      // frame start mid-burst: beats finish, then restart at the new base
      frame_base = 19'h140;
      flush_base = n_flush;
      do_burst(19'h104, 0, 1);
      fifo_level = 5'd13;
      repeat (2) @(negedge clk);
      check("pend_flush", 32'(n_flush - flush_base), 32'd1);
      check("pend_q_empty", 32'(exp_q.size()), 32'd0);
      fifo_level = 5'd0;
      do_burst(19'h140, 0, -1);
      fifo_level = 5'd13;

      // underrun: sticky, cleared by restart
      tick();
      fifo_rd = 1'b1; fifo_empty = 1'b1;
      tick();
      fifo_rd = 1'b0; fifo_empty = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("underrun_sticky", 32'(underrun), 32'd1);
      end
      pulse_fs();
      @(negedge clk);
      check("underrun_clear", 32'(underrun), 32'd0);

      // restart and underrun on the same cycle: clear wins
      tick();
      fifo_rd = 1'b1; fifo_empty = 1'b1; frame_start = 1'b1;
      tick();
      fifo_rd = 1'b0; fifo_empty = 1'b0; frame_start = 1'b0;
      @(negedge clk);
      check("underrun_clear_wins", 32'(underrun), 32'd0);
      check("flush_count", 32'(n_flush - flush_base), 32'd3);

      // reset during RECV
      fifo_level = 5'd0;
      wait_req(seen);
      check("rst_phase_addr", 32'(m.mem_addr), 32'h140);
      tick();
      m.mem_gnt = 1'b1;
      tick();
      m.mem_gnt = 1'b0;
      d = DATA_W'($urandom);
      m.mem_rvalid = 1'b1; m.mem_rdata = d;
      exp_q.push_back(d);
      tick();
      m.mem_rdata = DATA_W'($urandom);
      tick();
      rst = 1'b1; m.mem_rvalid = 1'b0;
      #1;
      check("rst_mid_req", 32'(m.mem_req), 32'd0);
      check("rst_mid_wr", 32'(fifo_wr), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_state", 32'(fsm_state), 32'(ST_IDLE));
      tick();
      tick();
      rst = 1'b0;
      beats_valid = 1'b0;
      m.mem_rvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         m.mem_rdata = DATA_W'($urandom);
         tick();
         @(negedge clk);
         check("stray_no_wr", 32'(fifo_wr), 32'd0);
      end
      m.mem_rvalid = 1'b0;
      @(negedge clk);
      check("stray_state", 32'(fsm_state), 32'(ST_IDLE));
      beats_valid = 1'b1;

      check("end_q_empty", 32'(exp_q.size()), 32'd0);
      check("end_frame_done", 32'(n_done), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
